// File: rtl/mem_wb_stage.sv
// Memory stage (data RAM store/load alignment) plus MEM/WB pipeline register.
// Latency: one cycle M->W. The RAM is written on the same edge that captures MEM/WB.
// No backpressure: stall_w holds MEM/WB; stores are not gated. flush_w overrides stall_w.
module mem_wb_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_w,
  input  logic        flush_w,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  input  logic [1:0]  memwrite_m,
  input  logic [2:0]  loadsel_m,
  input  logic        regwrite_m,
  input  logic [4:0]  writereg_m,
  output logic [31:0] readdata_w,
  output logic [31:0] aluout_w,
  output logic        regwrite_w,
  output logic [4:0]  writereg_w,
  output logic        memtoreg_w,
  output logic        misalign_err
);

  localparam logic [1:0] MW_SW  = 2'b01;
  localparam logic [1:0] MW_SH  = 2'b10;
  localparam logic [1:0] MW_SB  = 2'b11;
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LW   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LHU  = 3'b011;
  localparam logic [2:0] LD_LB   = 3'b100;
  localparam logic [2:0] LD_LBU  = 3'b101;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [2:0]    ld_sel;
  logic          store_mis;
  logic          load_mis;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;

  logic [31:0] readdata_d, readdata_q;
  logic [31:0] aluout_d,   aluout_q;
  logic        regwrite_d, regwrite_q;
  logic [4:0]  writereg_d, writereg_q;
  logic        memtoreg_d, memtoreg_q;
  logic        mis_d,      mis_q;

  // Decode address, alignment faults, store byte enables and load lane extraction.
  always_comb begin
    idx       = aluout_m[AW+1:2];
    off       = aluout_m[1:0];
    // A store and a load together is illegal; the store wins and the load is dropped.
    ld_sel    = (memwrite_m != 2'b00) ? LD_NONE : loadsel_m;
    store_mis = ((memwrite_m == MW_SW) && (off != 2'b00)) ||
                ((memwrite_m == MW_SH) && off[0]);
    load_mis  = ((ld_sel == LD_LW) && (off != 2'b00)) ||
                (((ld_sel == LD_LH) || (ld_sel == LD_LHU)) && off[0]);
    misalign  = store_mis | load_mis;

    be    = 4'b0000;
    wdata = writedata_m;
    case (memwrite_m)
      MW_SW: begin
        be    = 4'b1111;
        wdata = writedata_m;
      end
      MW_SH: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{writedata_m[15:0]}};
      end
      MW_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{writedata_m[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    if (store_mis) be = 4'b0000;

    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    case (ld_sel)
      LD_LW:   ld_data = rd_word;
      LD_LH:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      LD_LHU:  ld_data = {16'h0000, rd_shift[15:0]};
      LD_LB:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      LD_LBU:  ld_data = {24'h000000, rd_shift[7:0]};
      default: ld_data = 32'h0;
    endcase
    if (load_mis) ld_data = 32'h0;
  end

  // Data RAM byte-lane writes; deliberately not reset and not stalled.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // MEM/WB next state: flush bubbles, stall holds, otherwise capture.
  always_comb begin
    readdata_d = readdata_q;
    aluout_d   = aluout_q;
    regwrite_d = regwrite_q;
    writereg_d = writereg_q;
    memtoreg_d = memtoreg_q;
    mis_d      = mis_q;
    if (flush_w) begin
      readdata_d = 32'h0;
      aluout_d   = 32'h0;
      regwrite_d = 1'b0;
      writereg_d = 5'd0;
      memtoreg_d = 1'b0;
      mis_d      = 1'b0;
    end else if (!stall_w) begin
      readdata_d = ld_data;
      aluout_d   = aluout_m;
      regwrite_d = regwrite_m & ~misalign;
      writereg_d = writereg_m;
      memtoreg_d = (ld_sel != LD_NONE);
      mis_d      = misalign;
    end
  end

  // MEM/WB register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= 32'h0;
      aluout_q   <= 32'h0;
      regwrite_q <= 1'b0;
      writereg_q <= 5'd0;
      memtoreg_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      aluout_q   <= aluout_d;
      regwrite_q <= regwrite_d;
      writereg_q <= writereg_d;
      memtoreg_q <= memtoreg_d;
      mis_q      <= mis_d;
    end
  end

  assign readdata_w   = readdata_q;
  assign aluout_w     = aluout_q;
  assign regwrite_w   = regwrite_q;
  assign writereg_w   = writereg_q;
  assign memtoreg_w   = memtoreg_q;
  assign misalign_err = mis_q;

endmodule
